ktane_bus_decoder: RTL and testbench

KTANE_BUS_DECODER -- requirements
Module: ktane_bus_decoder

---
 rtl/ktane_bus_pkg.sv | 14 +
 rtl/ktane_region_match.sv | 27 ++
 rtl/ktane_bus_decoder.sv | 157 +++++++++++++++
 tb/tb_ktane_bus_decoder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ktane_bus_pkg.sv
// Shared types and constants for the KTANE bus decoder.
// Holds the transaction state encoding and the error response word.
package ktane_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        ERR    = 2'd3
    } bus_state_t;

    localparam logic [15:0] ERR_DATA = 16'hDEAD;

endpackage

// File: rtl/ktane_region_match.sv
// Combinational address decoder for the KTANE bus: one-hot region hit plus miss flag.
// Region i spans [base i, base i+1); the last region ends at REGION_TOP (exclusive).
module ktane_region_match #(
    parameter int ADDR_WIDTH = 16,
    parameter int N_SLAVES   = 6,
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] REGION_BASE =
        {16'hF330, 16'hE664, 16'hD998, 16'hCCCC, 16'hC000, 16'h0000},
    parameter logic [ADDR_WIDTH-1:0] REGION_TOP = 16'hFFFC
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [N_SLAVES-1:0]   hit,
    output logic                  miss
);

    for (genvar i = 0; i < N_SLAVES; i++) begin : g_region
        if (i == N_SLAVES - 1) begin : g_last
            assign hit[i] = (addr >= REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
                            (addr <  REGION_TOP);
        end else begin : g_mid
            assign hit[i] = (addr >= REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) &&
                            (addr <  REGION_BASE[(i+1)*ADDR_WIDTH +: ADDR_WIDTH]);
        end
    end

    assign miss = ~|hit;

endmodule

// File: rtl/ktane_bus_decoder.sv
// Single-master bus decoder: routes one transaction at a time to a mapped slave.
// Define BUS_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles without ready.
module ktane_bus_decoder
    import ktane_bus_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 16,
    parameter int N_SLAVES       = 6,
    parameter logic [N_SLAVES*ADDR_WIDTH-1:0] REGION_BASE =
        {16'hF330, 16'hE664, 16'hD998, 16'hCCCC, 16'hC000, 16'h0000},
    parameter logic [ADDR_WIDTH-1:0] REGION_TOP = 16'hFFFC,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           we,
    input  logic [ADDR_WIDTH-1:0]          addr,
    input  logic [DATA_WIDTH-1:0]          data,
    output logic [DATA_WIDTH-1:0]          q,
    output logic                           q_valid,
    output logic                           dec_err,
    output logic                           busy,
    output logic [N_SLAVES-1:0]            slv_en,
    output logic                           slv_we,
    output logic [ADDR_WIDTH-1:0]          slv_addr,
    output logic [DATA_WIDTH-1:0]          slv_wdata,
    input  logic [N_SLAVES*DATA_WIDTH-1:0] slv_rdata,
    input  logic [N_SLAVES-1:0]            slv_ready
);

    localparam logic [DATA_WIDTH-1:0] ERR_Q = DATA_WIDTH'(ERR_DATA);

    bus_state_t              state_r, state_s;
    logic [N_SLAVES-1:0]     hit_s;
    logic                    miss_s;
    logic                    ready_sel_s;
    logic [DATA_WIDTH-1:0]   rdata_sel_s;
    logic [DATA_WIDTH-1:0]   q_s;
    logic [N_SLAVES-1:0]     slv_en_s;
    logic                    slv_we_s;
    logic [ADDR_WIDTH-1:0]   slv_addr_s;
    logic [DATA_WIDTH-1:0]   slv_wdata_s;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_r, cnt_s;
`endif

    ktane_region_match #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .N_SLAVES    (N_SLAVES),
        .REGION_BASE (REGION_BASE),
        .REGION_TOP  (REGION_TOP)
    ) u_match (
        .addr (addr),
        .hit  (hit_s),
        .miss (miss_s)
    );

    // Selected slave's ready and read data; slv_en is one-hot only in ACCESS.
    always_comb begin
        ready_sel_s = |(slv_ready & slv_en);
        rdata_sel_s = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            rdata_sel_s = rdata_sel_s |
                          (slv_rdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{slv_en[i]}});
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s     = state_r;
        q_s         = q;
        slv_en_s    = '0;
        slv_we_s    = 1'b0;
        slv_addr_s  = slv_addr;
        slv_wdata_s = slv_wdata;
`ifdef BUS_TIMEOUT_EN
        cnt_s       = '0;
`endif
        case (state_r)
            IDLE: begin
                if (en) begin
                    slv_addr_s  = addr;
                    slv_wdata_s = data;
                    if (miss_s) begin
                        state_s = ERR;
                        q_s     = ERR_Q;
                    end else begin
                        state_s  = ACCESS;
                        slv_en_s = hit_s;
                        slv_we_s = we;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (ready_sel_s) begin
                    state_s = DONE;
                    q_s     = slv_we ? q : rdata_sel_s;
                end else begin
`ifdef BUS_TIMEOUT_EN
                    if (cnt_r == CNT_LAST) begin
                        state_s = ERR;
                        q_s     = ERR_Q;
                    end else begin
                        cnt_s    = cnt_r + CNT_W'(1);
                        slv_en_s = slv_en;
                        slv_we_s = slv_we;
                    end
`else
                    slv_en_s = slv_en;
                    slv_we_s = slv_we;
`endif
                end
            end
            DONE:    state_s = IDLE;
            ERR:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State and registered outputs; rst aborts any transaction on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            q         <= '0;
            q_valid   <= 1'b0;
            dec_err   <= 1'b0;
            busy      <= 1'b0;
            slv_en    <= '0;
            slv_we    <= 1'b0;
            slv_addr  <= '0;
            slv_wdata <= '0;
`ifdef BUS_TIMEOUT_EN
            cnt_r     <= '0;
`endif
        end else begin
            state_r   <= state_s;
            q         <= q_s;
            q_valid   <= (state_s == DONE) || (state_s == ERR);
            dec_err   <= (state_s == ERR);
            busy      <= (state_s != IDLE);
            slv_en    <= slv_en_s;
            slv_we    <= slv_we_s;
            slv_addr  <= slv_addr_s;
            slv_wdata <= slv_wdata_s;
`ifdef BUS_TIMEOUT_EN
            cnt_r     <= cnt_s;
`endif
        end
    end

endmodule

// File: tb/tb_ktane_bus_decoder.sv
// Directed self-checking bench for ktane_bus_decoder (default parameters).
// Outputs are sampled 1 time unit after each rising edge, where inputs are also driven.
module tb_ktane_bus_decoder;

    logic         clk = 1'b0;
    logic         rst, en, we;
    logic [15:0]  addr, data;
    logic [15:0]  q;
    logic         q_valid, dec_err, busy;
    logic [5:0]   slv_en;
    logic         slv_we;
    logic [15:0]  slv_addr, slv_wdata;
    logic [95:0]  slv_rdata;
    logic [5:0]   slv_ready;

    int errors = 0;
    int checks = 0;

    // Boundary table: address, expected one-hot select (0 = miss), expected read data.
    logic [15:0] b_addr [11] = '{16'h0000, 16'hBFFF, 16'hC000, 16'hCCCB, 16'hD998, 16'hE663,
                                 16'hE664, 16'hF330, 16'hFFFB, 16'hFFFC, 16'hFFFF};
    logic [5:0]  b_sel  [11] = '{6'b000001, 6'b000001, 6'b000010, 6'b000010, 6'b001000, 6'b001000,
                                 6'b010000, 6'b100000, 6'b100000, 6'b000000, 6'b000000};
    logic [15:0] b_q    [11] = '{16'h1001, 16'h1001, 16'h2002, 16'h2002, 16'h4004, 16'h4004,
                                 16'h5005, 16'h6006, 16'h6006, 16'hDEAD, 16'hDEAD};

    ktane_bus_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .we        (we),
        .addr      (addr),
        .data      (data),
        .q         (q),
        .q_valid   (q_valid),
        .dec_err   (dec_err),
        .busy      (busy),
        .slv_en    (slv_en),
        .slv_we    (slv_we),
        .slv_addr  (slv_addr),
        .slv_wdata (slv_wdata),
        .slv_rdata (slv_rdata),
        .slv_ready (slv_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; we = 1'b1; addr = 16'h0010; data = 16'h5A5A;
        slv_ready = 6'b111111;
        slv_rdata = {16'h6006, 16'h5005, 16'h4004, 16'h3003, 16'h2002, 16'h1001};
        tick; tick;
        checks++; if (q !== 16'h0000) begin errors++; $display("FAIL reset_q: got %h expected 0000", q); end
        checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL reset_q_valid: got %b expected 0", q_valid); end
        checks++; if (dec_err !== 1'b0) begin errors++; $display("FAIL reset_dec_err: got %b expected 0", dec_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (slv_en !== 6'b000000) begin errors++; $display("FAIL reset_slv_en: got %b expected 000000", slv_en); end
        checks++; if (slv_we !== 1'b0) begin errors++; $display("FAIL reset_slv_we: got %b expected 0", slv_we); end
        checks++; if (slv_addr !== 16'h0000) begin errors++; $display("FAIL reset_slv_addr: got %h expected 0000", slv_addr); end
        checks++; if (slv_wdata !== 16'h0000) begin errors++; $display("FAIL reset_slv_wdata: got %h expected 0000", slv_wdata); end
        rst = 1'b0; en = 1'b0; we = 1'b0; addr = 16'h0000; data = 16'h0000; slv_ready = 6'b000000;
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_read;
        slv_rdata[15:0] = 16'h1234; slv_ready = 6'b000001;
        we = 1'b0; addr = 16'h0010; en = 1'b1;
        tick;
        en = 1'b0;
        checks++; if (slv_en !== 6'b000001) begin errors++; $display("FAIL read_slv_en: got %b expected 000001", slv_en); end
        checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL read_early_valid: got %b expected 0", q_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL read_busy: got %b expected 1", busy); end
        checks++; if (slv_addr !== 16'h0010) begin errors++; $display("FAIL read_slv_addr: got %h expected 0010", slv_addr); end
        tick;
        checks++; if (q_valid !== 1'b1) begin errors++; $display("FAIL read_q_valid: got %b expected 1", q_valid); end
        checks++; if (q !== 16'h1234) begin errors++; $display("FAIL read_q: got %h expected 1234", q); end
        checks++; if (dec_err !== 1'b0) begin errors++; $display("FAIL read_dec_err: got %b expected 0", dec_err); end
        checks++; if (slv_en !== 6'b000000) begin errors++; $display("FAIL read_done_slv_en: got %b expected 000000", slv_en); end
        tick;
        checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL read_pulse_width: got %b expected 0", q_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_idle_busy: got %b expected 0", busy); end
        slv_ready = 6'b000000;
    endtask

    task automatic test_write;
        slv_rdata[47:32] = 16'h5555; slv_ready = 6'b111011;
        we = 1'b1; addr = 16'hCCCC; data = 16'h00AA; en = 1'b1;
        tick;
        en = 1'b0; we = 1'b0; data = 16'h0000;
        checks++; if (slv_en !== 6'b000100) begin errors++; $display("FAIL write_slv_en: got %b expected 000100", slv_en); end
        checks++; if (slv_we !== 1'b1) begin errors++; $display("FAIL write_slv_we: got %b expected 1", slv_we); end
        checks++; if (slv_wdata !== 16'h00AA) begin errors++; $display("FAIL write_slv_wdata: got %h expected 00aa", slv_wdata); end
        checks++; if (slv_addr !== 16'hCCCC) begin errors++; $display("FAIL write_slv_addr: got %h expected cccc", slv_addr); end
        for (int c = 1; c <= 4; c++) begin
            checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL write_wait_cycle%0d: q_valid got %b expected 0", c, q_valid); end
            if (c == 4) slv_ready[2] = 1'b1;
            tick;
        end
        checks++; if (q_valid !== 1'b1) begin errors++; $display("FAIL write_q_valid: got %b expected 1", q_valid); end
        checks++; if (q !== 16'h1234) begin errors++; $display("FAIL write_q_hold: got %h expected 1234", q); end
        checks++; if (dec_err !== 1'b0) begin errors++; $display("FAIL write_dec_err: got %b expected 0", dec_err); end
        slv_ready = 6'b000000;
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_miss;
        we = 1'b0; addr = 16'hFFFC; en = 1'b1;
        tick;
        en = 1'b0;
        checks++; if (q_valid !== 1'b1) begin errors++; $display("FAIL miss_q_valid: got %b expected 1", q_valid); end
        checks++; if (dec_err !== 1'b1) begin errors++; $display("FAIL miss_dec_err: got %b expected 1", dec_err); end
        checks++; if (q !== 16'hDEAD) begin errors++; $display("FAIL miss_q: got %h expected dead", q); end
        checks++; if (slv_en !== 6'b000000) begin errors++; $display("FAIL miss_slv_en: got %b expected 000000", slv_en); end
        tick;
        checks++; if (dec_err !== 1'b0) begin errors++; $display("FAIL miss_pulse_width: got %b expected 0", dec_err); end
        checks++; if (slv_en !== 6'b000000) begin errors++; $display("FAIL miss_after_slv_en: got %b expected 000000", slv_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL miss_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_boundaries;
        slv_rdata = {16'h6006, 16'h5005, 16'h4004, 16'h3003, 16'h2002, 16'h1001};
        slv_ready = 6'b111111; we = 1'b0;
        for (int i = 0; i < 11; i++) begin
            addr = b_addr[i]; en = 1'b1;
            tick;
            en = 1'b0;
            if (b_sel[i] == 6'b000000) begin
                checks++; if (dec_err !== 1'b1 || slv_en !== 6'b000000) begin
                    errors++; $display("FAIL bound_miss_%h: dec_err=%b slv_en=%b expected 1/000000", b_addr[i], dec_err, slv_en);
                end
                tick;
            end else begin
                checks++; if (slv_en !== b_sel[i]) begin
                    errors++; $display("FAIL bound_sel_%h: got %b expected %b", b_addr[i], slv_en, b_sel[i]);
                end
                tick;
                checks++; if (q_valid !== 1'b1 || q !== b_q[i]) begin
                    errors++; $display("FAIL bound_q_%h: q_valid=%b q=%h expected 1/%h", b_addr[i], q_valid, q, b_q[i]);
                end
                tick;
            end
        end
        slv_ready = 6'b000000;
    endtask

    task automatic test_back_to_back;
        int qv_count;
        logic seen_other;
        qv_count = 0; seen_other = 1'b0;
        we = 1'b0; addr = 16'h0010; en = 1'b1; slv_ready = 6'b000000;
        tick;
        addr = 16'hC000; en = 1'b1;
        tick;
        checks++; if (slv_en !== 6'b000001) begin errors++; $display("FAIL busy_slv_en: got %b expected 000001", slv_en); end
        checks++; if (slv_addr !== 16'h0010) begin errors++; $display("FAIL busy_slv_addr: got %h expected 0010", slv_addr); end
        en = 1'b0; slv_ready = 6'b000001;
        for (int k = 0; k < 6; k++) begin
            tick;
            if (slv_en == 6'b000010) seen_other = 1'b1;
            if (q_valid === 1'b1) begin
                qv_count++;
                checks++; if (q !== 16'h1001) begin errors++; $display("FAIL busy_q: got %h expected 1001", q); end
            end
        end
        checks++; if (qv_count !== 1) begin errors++; $display("FAIL busy_q_valid_count: got %0d expected 1", qv_count); end
        checks++; if (seen_other !== 1'b0) begin errors++; $display("FAIL busy_queued: got %b expected 0", seen_other); end
        slv_ready = 6'b000000;
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic test_timeout;
        int high_cycles;
        high_cycles = 0;
        we = 1'b0; addr = 16'hF330; en = 1'b1; slv_ready = 6'b000000;
        tick;
        en = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (slv_en !== 6'b100000) break;
            high_cycles++;
            tick;
        end
        checks++; if (high_cycles !== 15) begin errors++; $display("FAIL timeout_len: got %0d expected 15", high_cycles); end
        checks++; if (dec_err !== 1'b1) begin errors++; $display("FAIL timeout_dec_err: got %b expected 1", dec_err); end
        checks++; if (q !== 16'hDEAD) begin errors++; $display("FAIL timeout_q: got %h expected dead", q); end
        checks++; if (q_valid !== 1'b1) begin errors++; $display("FAIL timeout_q_valid: got %b expected 1", q_valid); end
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle_busy: got %b expected 0", busy); end
    endtask
`else
    task automatic test_long_wait;
        int bad;
        bad = 0;
        we = 1'b0; addr = 16'hF330; en = 1'b1; slv_ready = 6'b000000;
        tick;
        en = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (slv_en !== 6'b100000 || q_valid !== 1'b0) bad++;
            tick;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL wait_hold: got %0d bad cycles expected 0", bad); end
        slv_ready[5] = 1'b1;
        tick;
        checks++; if (q_valid !== 1'b1 || q !== 16'h6006) begin
            errors++; $display("FAIL wait_complete: q_valid=%b q=%h expected 1/6006", q_valid, q);
        end
        slv_ready = 6'b000000;
        tick;
    endtask
`endif

    task automatic test_reset_mid;
        logic qv;
        qv = 1'b0;
        we = 1'b0; addr = 16'h0010; en = 1'b1; slv_ready = 6'b000000;
        tick;
        en = 1'b0;
        tick;
        rst = 1'b1; slv_ready = 6'b000001;
        tick;
        checks++; if (q !== 16'h0000) begin errors++; $display("FAIL rstmid_q: got %h expected 0000", q); end
        checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL rstmid_q_valid: got %b expected 0", q_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (slv_en !== 6'b000000) begin errors++; $display("FAIL rstmid_slv_en: got %b expected 000000", slv_en); end
        checks++; if (slv_addr !== 16'h0000) begin errors++; $display("FAIL rstmid_slv_addr: got %h expected 0000", slv_addr); end
        rst = 1'b0; slv_ready = 6'b000000;
        for (int k = 0; k < 4; k++) begin
            tick;
            qv = qv | q_valid;
        end
        checks++; if (qv !== 1'b0) begin errors++; $display("FAIL rstmid_no_valid: got %b expected 0", qv); end
    endtask

    initial begin
        test_reset;
        test_read;
        test_write;
        test_miss;
        test_boundaries;
        test_back_to_back;
`ifdef BUS_TIMEOUT_EN
        test_timeout;
`else
        test_long_wait;
`endif
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
